mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the unified memory's single data port (address, size, write data, write enable; combinational read data) between two requesters: requester 0 is the pipelined CPU's load/store stage, requester 1 is a DMA/debug loader. Grants at most one access per cycle and stalls the loser. Requester 1 may lock the port for a bounded burst. Sits between the CPU's MEM stage, the loader and the `Mem` data port; the instruction port is untouched.

## Interface
- `MAX_BURST`, default 4: maximum consecutive locked grants to requester 1 (range 1–15).
- `CLK`, in, 1: clock; all state updates on the negedge, matching the codebase's registers and memory writes.
- `RST`, in, 1: reset, asynchronous, active-low.
- `Req0` / `Req1`, in, 1: access request from requester 0 / 1.
- `Addr0` / `Addr1`, in, 32: byte address.
- `Size0` / `Size1`, in, 2: access size; 00 byte, 01 halfword, 10/11 word.
- `WData0` / `WData1`, in, 32: store data.
- `WE0` / `WE1`, in, 1: store (1) or load (0).
- `Lock1`, in, 1: requester 1 requests to hold the port for its next access.
- `Gnt0` / `Gnt1`, out, 1: grant for the current cycle (combinational).
- `Stall0`, out, 1: `Req0 & ~Gnt0`; freezes the CPU pipeline.
- `MemAddr`, out, 32: to memory data port.
- `MemSize`, out, 2: to memory data port.
- `MemDataIn`, out, 32: to memory data port.
- `MemWE`, out, 1: to memory data port.
- `MemDataOut`, in, 32: read data from memory.
- `RData`, out, 32: `MemDataOut` broadcast; valid for the granted requester only.
- `ConflictCnt`, out, 16: saturating count of cycles with `Req0 & Req1`.

## Operation
- State: `Last` (1 bit, last granted requester), `Owner` (IDLE / LOCK1), `BurstCnt` (4 bits), `ConflictCnt`.
- Grant is combinational from the requests and the registered state:
  - Only one request: that requester wins.
  - `Owner`=LOCK1 with `Req1` and `BurstCnt < MAX_BURST`: requester 1 wins.
  - Otherwise on conflict: the requester with index ≠ `Last` wins (round-robin).
  - No request: no grant; `MemWE`=0; `MemAddr`/`MemSize`/`MemDataIn` driven from requester 0's inputs.
- The mux routes the winner's address, size, data and write enable to memory. `MemWE = WEx & Gntx`.
- Negedge updates:
  - `Last` takes the winner's index; unchanged when idle.
  - Grant to requester 1 with `Lock1`: `Owner`=LOCK1 and `BurstCnt` increments.
  - Any other cycle (no grant to 1, or `Lock1` low): `Owner`=IDLE and `BurstCnt`=0.
  - Burst exhausted (`BurstCnt`=MAX_BURST) with `Req0` pending: requester 0 is granted next, and the burst resets.
  - Burst exhausted without `Req0`: requester 1 continues, and `BurstCnt` holds at MAX_BURST.
- `ConflictCnt` increments on conflict cycles and saturates at 16'hFFFF.
- While `RST`=0 (async): all state is 0 and `Owner`=IDLE. `Gnt0`, `Gnt1`, `MemWE` and `Stall0` are forced to 0, so a reset mid-burst drops the lock immediately.

## Timing
- Zero-cycle latency. A granted access is presented to memory in the same cycle. The store commits at that cycle's negedge. Load data is valid combinationally before that negedge.
- A requester holds `Req`, `Addr`, `Size`, `WData` and `WE` stable until it sees a grant. A request dropped without a grant is legal and has no side effect.
- Worst-case wait for requester 0 is `MAX_BURST` cycles under lock and 1 cycle otherwise.
- `Stall0` must settle before the negedge, because pipeline registers capture on the negedge.

## Configuration
- `ARB_FIXED_PRIO_EN`
  - Defined: requester 0 always wins a conflict. `Lock1` and `BurstCnt` are ignored, with `Owner` tied to IDLE. `Last` is still tracked.
  - Undefined: round-robin plus bounded lock, as described above.

## Structure
- Package `arb_pkg`:
  - Requester index constants `REQ_CPU`=0 and `REQ_DMA`=1.
  - Size encodings `SZ_BYTE`, `SZ_HALF` and `SZ_WORD`.
  - `Owner` state encoding.
  - `CNT_W`=16.
- Sub-module `arb_burst_ctr`: a 4-bit counter with clear, increment and hold-at-limit, plus a `limit_hit` output. Registered on the negedge with the async active-low reset.

## Test plan
1. Only `Req0`: load word at 0x40 (memory holds 0xDEADBEEF) → `Gnt0`=1, `RData`=0xDEADBEEF, `Stall0`=0.
2. Both requests every cycle, no lock, 6 cycles → grants alternate 1,0,1,0,1,0 (starting from `Last`=0 after reset). `Stall0` is high on cycles 1, 3 and 5. `ConflictCnt`=6.
3. `Lock1`=1 with `Req1` held, `MAX_BURST`=4, and `Req0` high throughout → `Gnt1` for 4 cycles, then `Gnt0` for 1 cycle, then `Gnt1` again.
4. `Req1` store byte 0xA5 to 0x101 while `Req0` is idle → `MemWE`=1, `MemSize`=00, `MemAddr`=0x101. After the negedge, a readback of 0x101 returns 0xA5.
5. `RST` pulsed low mid-burst (BurstCnt=2) → grants and `MemWE` go to 0 immediately. After release, a conflict is granted to requester 1 (`Last`=0). `ConflictCnt` restarts from 0.
6. With `ARB_FIXED_PRIO_EN`: both requests for 5 cycles with `Lock1`=1 → `Gnt0`=1 on all 5 cycles and `Gnt1` is never asserted.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state encoding for the memory data port arbiter
package arb_pkg;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int CNT_W = 16;
  typedef enum logic {IDLE, LOCK1} owner_t;
endpackage

// File: rtl/arb_burst_ctr.sv
// arb_burst_ctr: negedge burst counter with clear, increment and hold at LIMIT
module arb_burst_ctr #(
  parameter logic [3:0] LIMIT = 4'd4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic limit_hit
);
  logic [3:0] cnt;
  assign limit_hit = cnt >= LIMIT;
  always_ff @(negedge CLK or negedge RST)
    if (!RST) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !limit_hit) cnt <= cnt + 4'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the memory data port between the CPU (0) and a DMA/loader (1).
// Define ARB_FIXED_PRIO_EN for fixed CPU priority; default is round-robin plus bounded lock.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [31:0]      Addr0,
  input  logic [31:0]      Addr1,
  input  logic [1:0]       Size0,
  input  logic [1:0]       Size1,
  input  logic [31:0]      WData0,
  input  logic [31:0]      WData1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic             Lock1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Stall0,
  output logic [31:0]      MemAddr,
  output logic [1:0]       MemSize,
  output logic [31:0]      MemDataIn,
  output logic             MemWE,
  input  logic [31:0]      MemDataOut,
  output logic [31:0]      RData,
  output logic [CNT_W-1:0] ConflictCnt
);
  logic last, win1;
`ifdef ARB_FIXED_PRIO_EN
  assign win1 = Req1 & ~Req0;
`else
  localparam logic [3:0] LIMIT = 4'(MAX_BURST);
  owner_t owner, owner_nxt;
  logic limit_hit;
  always_comb owner_nxt = (Gnt1 && Lock1) ? LOCK1 : IDLE;
  always_ff @(negedge CLK or negedge RST)
    if (!RST) owner <= IDLE;
    else owner <= owner_nxt;
  arb_burst_ctr #(.LIMIT(LIMIT)) u_burst (
    .CLK(CLK),
    .RST(RST),
    .clr(~(Gnt1 & Lock1)),
    .inc(Gnt1 & Lock1),
    .limit_hit(limit_hit)
  );
  // an unexhausted lock beats round-robin; otherwise the non-last requester wins a conflict
  assign win1 = Req1 & (~Req0 | (last == REQ_CPU) | (owner == LOCK1 & ~limit_hit));
`endif
  assign Gnt1 = RST & win1;
  assign Gnt0 = RST & Req0 & ~win1;
  assign Stall0 = RST & Req0 & ~Gnt0;
  assign MemAddr = Gnt1 ? Addr1 : Addr0;
  assign MemSize = Gnt1 ? Size1 : Size0;
  assign MemDataIn = Gnt1 ? WData1 : WData0;
  assign MemWE = (WE1 & Gnt1) | (WE0 & Gnt0);
  assign RData = MemDataOut;
  always_ff @(negedge CLK or negedge RST)
    if (!RST) begin
      last <= REQ_CPU;
      ConflictCnt <= '0;
    end else begin
      if (Gnt0 || Gnt1) last <= Gnt1 ? REQ_DMA : REQ_CPU;
      if (Req0 && Req1 && !(&ConflictCnt)) ConflictCnt <= ConflictCnt + 1'b1;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; driver queues expectations, monitor checks mid-cycle
module tb_mem_port_arbiter;
  import arb_pkg::*;
  logic CLK = 1'b0, RST = 1'b0;
  logic Req0 = 0, Req1 = 0, WE0 = 0, WE1 = 0, Lock1 = 0;
  logic [31:0] Addr0 = 32'h40, Addr1 = 32'h80, WData0 = 32'h1111_1111, WData1 = 32'h0;
  logic [1:0] Size0 = SZ_WORD, Size1 = SZ_WORD;
  logic Gnt0, Gnt1, Stall0, MemWE;
  logic [31:0] MemAddr, MemDataIn, MemDataOut, RData;
  logic [1:0] MemSize;
  logic [15:0] ConflictCnt;
  int errors = 0, checks = 0;
  int exp_cc = 0;

  typedef struct packed {
    logic [63:0] nm;
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic        chk_rd;
    logic [31:0] rd;
    logic [15:0] cc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:511] = '{9'h40: 8'hEF, 9'h41: 8'hBE, 9'h42: 8'hAD, 9'h43: 8'hDE, default: 8'h00};
  logic [8:0] ma;
  assign ma = MemAddr[8:0];
  always_comb
    MemDataOut = (MemSize == SZ_BYTE) ? {24'h0, mem[ma]} :
                 (MemSize == SZ_HALF) ? {16'h0, mem[9'(ma + 9'd1)], mem[ma]} :
                 {mem[9'(ma + 9'd3)], mem[9'(ma + 9'd2)], mem[9'(ma + 9'd1)], mem[ma]};
  always @(negedge CLK)
    if (MemWE) begin
      mem[ma] <= MemDataIn[7:0];
      if (MemSize != SZ_BYTE) mem[9'(ma + 9'd1)] <= MemDataIn[15:8];
      if (MemSize[1]) begin
        mem[9'(ma + 9'd2)] <= MemDataIn[23:16];
        mem[9'(ma + 9'd3)] <= MemDataIn[31:24];
      end
    end

  mem_port_arbiter #(.MAX_BURST(4)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(Req0), .Req1(Req1), .Addr0(Addr0), .Addr1(Addr1),
    .Size0(Size0), .Size1(Size1), .WData0(WData0), .WData1(WData1),
    .WE0(WE0), .WE1(WE1), .Lock1(Lock1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Stall0(Stall0),
    .MemAddr(MemAddr), .MemSize(MemSize), .MemDataIn(MemDataIn), .MemWE(MemWE),
    .MemDataOut(MemDataOut), .RData(RData), .ConflictCnt(ConflictCnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input logic [63:0] nm, input logic [63:0] what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s %0s: got %h expected %h at %0t", nm, what, act, exp, $time);
    end
  endtask

  // one cycle: queue the expectation for the current inputs, then advance to just after the negedge
  task automatic cyc(input logic [63:0] nm, input logic g0, input logic g1, input logic st0,
                     input logic we, input logic [1:0] sz, input logic [31:0] addr,
                     input logic chk_rd, input logic [31:0] rd);
    exp_t e;
    e.nm = nm;
    e.ctl = {g0, g1, st0, we, sz};
    e.addr = addr;
    e.chk_rd = chk_rd;
    e.rd = rd;
    e.cc = 16'(exp_cc);
    sb.push_back(e);
    if (RST && Req0 && Req1) exp_cc++;
    @(negedge CLK);
    #1;
  endtask

  initial forever begin
    exp_t e;
    @(posedge CLK);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "ctl", 32'({Gnt0, Gnt1, Stall0, MemWE, MemSize}), 32'(e.ctl));
      chk(e.nm, "addr", MemAddr, e.addr);
      chk(e.nm, "ccnt", 32'(ConflictCnt), 32'(e.cc));
      if (e.chk_rd) chk(e.nm, "rdata", RData, e.rd);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Req0 = 1; Req1 = 1;
    @(negedge CLK);
    #1;
    cyc("rst", 0, 0, 0, 0, SZ_WORD, 32'h40, 0, 0);
    RST = 1; Req1 = 0;
    cyc("t1_ld", 1, 0, 0, 0, SZ_WORD, 32'h40, 1, 32'hDEAD_BEEF);
`ifdef ARB_FIXED_PRIO_EN
    Req1 = 1; Lock1 = 1;
    repeat (5) cyc("t6_fix", 1, 0, 0, 0, SZ_WORD, 32'h40, 0, 0);
`else
    Req1 = 1;
    for (int k = 0; k < 6; k++)
      if (k % 2 == 0) cyc("t2_rr", 0, 1, 1, 0, SZ_WORD, 32'h80, 0, 0);
      else cyc("t2_rr", 1, 0, 0, 0, SZ_WORD, 32'h40, 0, 0);
    Lock1 = 1;
    repeat (4) cyc("t3_lock", 0, 1, 1, 0, SZ_WORD, 32'h80, 0, 0);
    cyc("t3_lock", 1, 0, 0, 0, SZ_WORD, 32'h40, 0, 0);
    cyc("t3_lock", 0, 1, 1, 0, SZ_WORD, 32'h80, 0, 0);
`endif
    Req0 = 0; Lock1 = 0; Addr1 = 32'h101; Size1 = SZ_BYTE; WData1 = 32'hA5; WE1 = 1;
    cyc("t4_wr", 0, 1, 0, 1, SZ_BYTE, 32'h101, 0, 0);
    WE1 = 0;
    cyc("t4_rd", 0, 1, 0, 0, SZ_BYTE, 32'h101, 1, 32'hA5);
`ifndef ARB_FIXED_PRIO_EN
    Addr1 = 32'h80; Size1 = SZ_WORD; Lock1 = 1;
    repeat (6) cyc("t5_exh", 0, 1, 0, 0, SZ_WORD, 32'h80, 0, 0);
    Req0 = 1;
    cyc("t5_exh0", 1, 0, 0, 0, SZ_WORD, 32'h40, 0, 0);
    Req0 = 0;
    repeat (2) cyc("t5_bst", 0, 1, 0, 0, SZ_WORD, 32'h80, 0, 0);
    Req0 = 1; WE1 = 1; WData1 = 32'h5A; Addr1 = 32'h101; Size1 = SZ_BYTE;
    RST = 0; exp_cc = 0;
    cyc("t5_rst", 0, 0, 0, 0, SZ_WORD, 32'h40, 0, 0);
    RST = 1; WE1 = 0; Lock1 = 0;
    cyc("t5_post", 0, 1, 1, 0, SZ_BYTE, 32'h101, 1, 32'hA5);
    cyc("t5_rr", 1, 0, 0, 0, SZ_WORD, 32'h40, 0, 0);
`endif
    Req0 = 0; Req1 = 0;
    @(posedge CLK);
    #1;
    chk("drain", "pending", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
